// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the mux_scan block and its scan sequencer.
//   mode_e         : encoding of the mode input (manual / scan)
//   addr_in_range  : range check of a channel address against the channel
//                    count, done at 32 bits so it is safe for any SEL_W
package mux_scan_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // True when addr names an existing channel. Callers zero-extend the
    // address to 32 bits so a CH that is not a power of two compares cleanly.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned ch);
        return (addr < ch);
    endfunction

    // Width of a counter able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// scan_seq
// Channel pointer and dwell counter for mux_scan's auto-scan mode.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   adv    in   advance one scan step (enable & scan mode)
//   clr    in   force pointer and dwell counter to 0 (enable & manual mode)
//   ptr    out  current channel pointer
//   first  out  high on the first dwell cycle of channel 0
// With adv and clr both low the pointer and counter hold, which is how a
// paused scan resumes exactly where it stopped.
module scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned CH    = 8,
    parameter int unsigned SEL_W = $clog2(CH),
    parameter int unsigned DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    output logic [SEL_W-1:0] ptr,
    output logic             first
);

    localparam int unsigned DCNT_W = cnt_width(DWELL);

    localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(CH - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

    logic [DCNT_W-1:0] dcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            dcnt <= '0;
        end else if (clr) begin
            ptr  <= '0;
            dcnt <= '0;
        end else if (adv) begin
            if (dcnt == DCNT_LAST) begin
                dcnt <= '0;
                if (ptr == PTR_LAST) begin
                    ptr <= '0;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_comb begin
        first = (ptr == '0) && (dcnt == '0);
    end

endmodule

// File: rtl/mux_scan.sv
// mux_scan
// Registered CH-channel, W-bit multiplexer with a manual (external address)
// mode and an auto-scan mode that dwells DWELL cycles on each channel.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   enable; low pauses the scan and blanks the output
//   mode      in   0 = manual, 1 = scan
//   D         in   packed channel data, channel k = D[k*W +: W]
//   addy      in   manual-mode channel select (ignored in scan mode)
//   valid     out  dout holds a legal channel sample
//   dout      out  selected channel data
//   cur_addy  out  channel index that produced dout
//   frame     out  one-cycle marker on the first cycle of channel 0 in scan
//   addr_err  out  manual address was >= CH
// All outputs are registered; inputs sampled at one edge show up after it.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int unsigned CH    = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned SEL_W = $clog2(CH),
    parameter int unsigned DWELL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [CH*W-1:0]   D,
    input  logic [SEL_W-1:0]  addy,
    output logic              valid,
    output logic [W-1:0]      dout,
    output logic [SEL_W-1:0]  cur_addy,
    output logic              frame,
    output logic              addr_err
);

    mode_e            mode_q;
    logic             adv;
    logic             clr;
    logic [SEL_W-1:0] ptr;
    logic             first;

    logic [SEL_W-1:0] mux_sel;
    logic [W-1:0]     mux_data;

    logic             nxt_valid;
    logic [W-1:0]     nxt_dout;
    logic [SEL_W-1:0] nxt_cur;
    logic             nxt_frame;
    logic             nxt_err;

    always_comb begin
        mode_q = mode_e'(mode);
        adv    = en & (mode_q == MODE_SCAN);
        clr    = en & (mode_q == MODE_MANUAL);
    end

    scan_seq #(
        .CH    (CH),
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) u_seq (
        .clk   (clk),
        .rst   (rst),
        .adv   (adv),
        .clr   (clr),
        .ptr   (ptr),
        .first (first)
    );

    // Compare-and-select mux: an address past the last channel simply
    // matches nothing and yields zero rather than reading outside D.
    always_comb begin
        mux_data = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (mux_sel == SEL_W'(k)) begin
                mux_data = D[k*W +: W];
            end
        end
    end

    always_comb begin
        mux_sel   = addy;
        nxt_valid = 1'b0;
        nxt_dout  = '0;
        nxt_cur   = cur_addy;
        nxt_frame = 1'b0;
        nxt_err   = 1'b0;
        if (en) begin
            if (mode_q == MODE_SCAN) begin
                mux_sel   = ptr;
                nxt_valid = 1'b1;
                nxt_dout  = mux_data;
                nxt_cur   = ptr;
                nxt_frame = first;
            end else if (addr_in_range(32'(addy), CH)) begin
                nxt_valid = 1'b1;
                nxt_dout  = mux_data;
                nxt_cur   = addy;
            end else begin
                nxt_err   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            dout     <= '0;
            cur_addy <= '0;
            frame    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            valid    <= nxt_valid;
            dout     <= nxt_dout;
            cur_addy <= nxt_cur;
            frame    <= nxt_frame;
            addr_err <= nxt_err;
        end
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Successor to the team's fixed 8:1 single-bit enable/valid mux.
- Adds two behaviours the old mux lacked: a manual mode (external address) and an auto-scan mode (internal sequencer visits each channel for DWELL cycles).
- Also adds a frame marker and out-of-range address detection.
- Sits between parallel sensor/data lanes and a single serial consumer.

Parameters:
- CH, 8, number of input channels (2..256).
- W, 1, bits per channel.
- SEL_W, $clog2(CH), address width.
- DWELL, 1, cycles spent on each channel in scan mode (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; low pauses the block and blanks the output.
- mode  in  1  0 = manual, 1 = scan.
- D  in  CH*W  packed channel data; channel k = D[k*W +: W].
- addy  in  SEL_W  manual-mode channel select.
- valid  out  1  dout holds a legal channel sample.
- dout  out  W  selected channel data.
- cur_addy  out  SEL_W  channel index that produced dout.
- frame  out  1  one-cycle marker: first cycle of channel 0 in scan mode.
- addr_err  out  1  manual address was >= CH.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset: valid=0, dout=0, cur_addy=0, frame=0, addr_err=0; scan pointer=0, dwell counter=0. Reset wins over every other input, including mid-scan.
- Latency: 1 cycle. Inputs sampled at edge n appear on the outputs after edge n.
- en=0:
  - Next outputs are valid=0, dout=0, frame=0, addr_err=0; cur_addy holds.
  - Scan pointer and dwell counter hold (pause, not restart).
- Manual mode (en=1, mode=0):
  - addy<CH: dout=D[addy], cur_addy=addy, valid=1, addr_err=0.
  - addy>=CH (only when CH is not a power of 2): dout=0, valid=0, addr_err=1, cur_addy holds.
  - Scan pointer and dwell counter are forced to 0.
  - frame=0.
- Scan mode (en=1, mode=1):
  - Output: dout=D[ptr], cur_addy=ptr, valid=1, addr_err=0.
  - frame=1 iff ptr==0 and dcnt==0, else 0.
  - dcnt==DWELL-1: dcnt resets to 0; ptr advances to ptr+1, wrapping from CH-1 to 0. Otherwise dcnt increments.
  - Switching manual->scan always starts at channel 0 with dcnt=0, so the first scan output asserts frame.
  - With DWELL=1, ptr advances every cycle and frame asserts once every CH cycles.
- addy is ignored in scan mode. D is sampled live each cycle, not latched per dwell.

Decomposition:
- Shared package mux_scan_pkg holds:
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
  - A function computing SEL_W-safe range checks.
- Natural sub-module: scan_seq, containing ptr and dcnt with wrap logic.
  - Inputs: clk, rst, adv (en & mode), clr (en & ~mode).
  - Outputs: ptr, first (ptr==0 && dcnt==0).
- Top level is the registered mux plus output logic.

Test Plan (CH=8, W=4, DWELL=2 unless noted):
- Reset: assert rst for 2 cycles with en=1, mode=1 -> all outputs 0 during reset and one cycle after release. Then first output is cur_addy=0, frame=1.
- Manual select: D=32'h76543210, mode=0, en=1, addy=5 -> next cycle dout=4'h5, valid=1, cur_addy=5, addr_err=0. Change addy to 2 -> following cycle dout=4'h2.
- Scan sequence: same D, mode=1 for 18 cycles -> cur_addy sequence 0,0,1,1,...,7,7,0,0. frame=1 on cycles 1 and 17 only. dout tracks the channel value.
- Pause and resume: in scan, drop en for 3 cycles while on channel 3, second dwell cycle -> valid=0, dout=0 for 3 cycles. After en returns: one output on channel 3, then channel 4 (no skip, no restart).
- Out of range (CH=6, SEL_W=3): manual addy=7 -> valid=0, dout=0, addr_err=1, cur_addy unchanged. addy=5 -> valid=1, addr_err=0.
- Mode switch mid-scan: scan to channel 4, switch to manual (addy=1) for 1 cycle, then back to scan -> scan resumes at channel 0 with frame=1.
